light_sequence_monitor: RTL and testbench

Passive checker on the two-lane light outputs of the traffic-light sequencer: samples `light_a`/`light_b` (sequencer `out`/`out2`) every clock and flags unsafe or malformed sequences. It tracks per-lane phase, dwell time and the all-red clearance interval, and latches the first fault with a code. It sits beside the sequencer in the top level and in benches as a live safety monitor. It never drives the sequencer.

---
 rtl/light_sequence_monitor.sv | 196 +++++++++++++++++++
 tb/tb_light_sequence_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/light_sequence_monitor.sv
// Passive safety monitor for the two-lane traffic-light sequencer outputs.
// Tracks per-lane phase, dwell and all-red clearance, and latches the first fault with a code.
module light_sequence_monitor #(
   parameter int CNT_W      = 32,
   parameter int MIN_GREEN  = 20,
   parameter int MIN_YELLOW = 5,
   parameter int MAX_RED    = 200,
   parameter int CLEAR      = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       light_a,
   input  logic [1:0]       light_b,
   input  logic             clear,
   output logic             fault,
   output logic [2:0]       fault_code,
   output logic             fault_lane,
   output logic [7:0]       fault_count,
   output logic [CNT_W-1:0] dwell_a,
   output logic [CNT_W-1:0] dwell_b,
   output logic             change_a,
   output logic             change_b
);

   localparam logic [1:0] PH_RED     = 2'b00;
   localparam logic [1:0] PH_GREEN   = 2'b01;
   localparam logic [1:0] PH_YELLOW  = 2'b10;
   localparam logic [1:0] PH_ILLEGAL = 2'b11;

   localparam int AR_W = (CLEAR > 0) ? $clog2(CLEAR + 1) : 1;
   localparam logic [AR_W-1:0]  CLEAR_C      = AR_W'(CLEAR);
   localparam logic [AR_W-1:0]  AR_ONE       = AR_W'(1);
   localparam logic [CNT_W-1:0] MIN_GREEN_C  = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] MIN_YELLOW_C = CNT_W'(MIN_YELLOW);
   localparam logic [CNT_W-1:0] MAX_RED_C    = CNT_W'(MAX_RED);
   localparam logic [CNT_W-1:0] DWELL_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] DWELL_MAX    = {CNT_W{1'b1}};

   localparam logic [2:0] CODE_NONE      = 3'd0;
   localparam logic [2:0] CODE_ENCODING  = 3'd1;
   localparam logic [2:0] CODE_TRANS     = 3'd2;
   localparam logic [2:0] CODE_CONFLICT  = 3'd3;
   localparam logic [2:0] CODE_S_GREEN   = 3'd4;
   localparam logic [2:0] CODE_S_YELLOW  = 3'd5;
   localparam logic [2:0] CODE_TIMEOUT   = 3'd6;
   localparam logic [2:0] CODE_CLEARANCE = 3'd7;

   typedef struct packed {
      logic [1:0]       prev;
      logic [CNT_W-1:0] dwell;
      logic             change;
      logic             illegal;
      logic             trans;
      logic             clr;
      logic             sgreen;
      logic             syellow;
      logic             timeout;
   } lane_eval_t;

   // Next phase/dwell and fault flags for one lane; ar_short means the all-red interval is too short.
   function automatic lane_eval_t eval_lane(input logic [1:0] sample, input logic [1:0] prev,
                                            input logic [CNT_W-1:0] dwell, input logic ar_short);
      lane_eval_t r;
      r         = '0;
      r.prev    = prev;
      r.dwell   = dwell;
      r.illegal = (sample == PH_ILLEGAL);
      if (r.illegal) begin
         r.dwell = dwell;
      end else if (sample == prev) begin
         r.dwell = (dwell == DWELL_MAX) ? dwell : dwell + DWELL_ONE;
      end else begin
         r.prev   = sample;
         r.dwell  = DWELL_ONE;
         r.change = 1'b1;
         case ({prev, sample})
            {PH_RED, PH_GREEN}:    r.clr     = ar_short;
            {PH_GREEN, PH_YELLOW}: r.sgreen  = (dwell < MIN_GREEN_C);
            {PH_YELLOW, PH_RED}:   r.syellow = (dwell < MIN_YELLOW_C);
            default:               r.trans   = 1'b1;
         endcase
      end
      r.timeout = (sample == PH_RED) && (r.dwell == MAX_RED_C);
      return r;
   endfunction

   logic [1:0]       prev_a_r, prev_b_r;
   logic [CNT_W-1:0] dwell_a_r, dwell_b_r;
   logic             change_a_r, change_b_r;
   logic [AR_W-1:0]  all_red_r, all_red_nxt_s;
   logic             ar_short_s, conflict_s;
   lane_eval_t       lane_a_s, lane_b_s;
   logic             fault_any_s, lane_s;
   logic [2:0]       code_s;
   logic             fault_r, fault_lane_r;
   logic [2:0]       fault_code_r;
   logic [7:0]       fault_count_r;

   // Per-lane evaluation, conflict detection and all-red clearance tracking.
   always_comb begin
      ar_short_s = (all_red_r < CLEAR_C);
      lane_a_s   = eval_lane(light_a, prev_a_r, dwell_a_r, ar_short_s);
      lane_b_s   = eval_lane(light_b, prev_b_r, dwell_b_r, ar_short_s);
      conflict_s = (light_a != PH_RED) && (light_b != PH_RED);
      if ((light_a == PH_RED) && (light_b == PH_RED)) begin
         all_red_nxt_s = (all_red_r == CLEAR_C) ? all_red_r : all_red_r + AR_ONE;
      end else begin
         all_red_nxt_s = {AR_W{1'b0}};
      end
   end

   // First-fault priority: conflict, encoding, transition, clearance, short green, short yellow, timeout.
   always_comb begin
      fault_any_s = 1'b1;
      code_s      = CODE_NONE;
      lane_s      = 1'b0;
      if (conflict_s) begin
         code_s = CODE_CONFLICT;
      end else if (lane_a_s.illegal || lane_b_s.illegal) begin
         code_s = CODE_ENCODING;
         lane_s = ~lane_a_s.illegal;
      end else if (lane_a_s.trans || lane_b_s.trans) begin
         code_s = CODE_TRANS;
         lane_s = ~lane_a_s.trans;
      end else if (lane_a_s.clr || lane_b_s.clr) begin
         code_s = CODE_CLEARANCE;
         lane_s = ~lane_a_s.clr;
      end else if (lane_a_s.sgreen || lane_b_s.sgreen) begin
         code_s = CODE_S_GREEN;
         lane_s = ~lane_a_s.sgreen;
      end else if (lane_a_s.syellow || lane_b_s.syellow) begin
         code_s = CODE_S_YELLOW;
         lane_s = ~lane_a_s.syellow;
      end else if (lane_a_s.timeout || lane_b_s.timeout) begin
         code_s = CODE_TIMEOUT;
         lane_s = ~lane_a_s.timeout;
      end else begin
         fault_any_s = 1'b0;
      end
   end

   // Lane phase, dwell counters, change pulses and all-red counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_a_r   <= PH_RED;
         prev_b_r   <= PH_RED;
         dwell_a_r  <= {CNT_W{1'b0}};
         dwell_b_r  <= {CNT_W{1'b0}};
         change_a_r <= 1'b0;
         change_b_r <= 1'b0;
         all_red_r  <= CLEAR_C;
      end else begin
         prev_a_r   <= lane_a_s.prev;
         prev_b_r   <= lane_b_s.prev;
         dwell_a_r  <= lane_a_s.dwell;
         dwell_b_r  <= lane_b_s.dwell;
         change_a_r <= lane_a_s.change;
         change_b_r <= lane_b_s.change;
         all_red_r  <= all_red_nxt_s;
      end
   end

   // Sticky first-fault latch and saturating fault-event counter; a fault coincident with clear wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         fault_r       <= 1'b0;
         fault_code_r  <= CODE_NONE;
         fault_lane_r  <= 1'b0;
         fault_count_r <= 8'd0;
      end else if (clear) begin
         fault_r       <= fault_any_s;
         fault_code_r  <= code_s;
         fault_lane_r  <= lane_s;
         fault_count_r <= fault_any_s ? 8'd1 : 8'd0;
      end else begin
         if (fault_any_s && !fault_r) begin
            fault_r      <= 1'b1;
            fault_code_r <= code_s;
            fault_lane_r <= lane_s;
         end
         if (fault_any_s && (fault_count_r != 8'hFF)) begin
            fault_count_r <= fault_count_r + 8'd1;
         end
      end
   end

   assign fault       = fault_r;
   assign fault_code  = fault_code_r;
   assign fault_lane  = fault_lane_r;
   assign fault_count = fault_count_r;
   assign dwell_a     = dwell_a_r;
   assign dwell_b     = dwell_b_r;
   assign change_a    = change_a_r;
   assign change_b    = change_b_r;

endmodule

// File: tb/tb_light_sequence_monitor.sv
// Directed self-checking bench for light_sequence_monitor with hand-computed expectations.
module tb_light_sequence_monitor;

   localparam logic [1:0] R = 2'b00;
   localparam logic [1:0] G = 2'b01;
   localparam logic [1:0] Y = 2'b10;
   localparam logic [1:0] X = 2'b11;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic [1:0]  light_a, light_b;
   logic        fault, fault_lane, change_a, change_b;
   logic [2:0]  fault_code;
   logic [7:0]  fault_count;
   logic [31:0] dwell_a, dwell_b;

   int num_checks = 0;
   int num_errors = 0;

   always #5 clk = ~clk;

   light_sequence_monitor dut (
      .clk(clk), .reset(reset), .light_a(light_a), .light_b(light_b), .clear(clear),
      .fault(fault), .fault_code(fault_code), .fault_lane(fault_lane), .fault_count(fault_count),
      .dwell_a(dwell_a), .dwell_b(dwell_b), .change_a(change_a), .change_b(change_b)
   );

   task automatic step(input logic [1:0] a, input logic [1:0] b);
      light_a = a;
      light_b = b;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear = 1'b0;
      step(R, R);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear = 1'b0;
      step(G, Y);
      step(R, R);
      reset = 1'b0;
      num_checks++;
      if (fault !== 1'b0) begin num_errors++; $display("FAIL reset_fault: got %0d expected 0", fault); end
      num_checks++;
      if (fault_code !== 3'd0) begin num_errors++; $display("FAIL reset_code: got %0d expected 0", fault_code); end
      num_checks++;
      if (fault_count !== 8'd0) begin num_errors++; $display("FAIL reset_count: got %0d expected 0", fault_count); end
      num_checks++;
      if (dwell_a !== 32'd0 || dwell_b !== 32'd0) begin
         num_errors++; $display("FAIL reset_dwell: got %0d/%0d expected 0/0", dwell_a, dwell_b);
      end
      num_checks++;
      if (change_a !== 1'b0 || change_b !== 1'b0) begin
         num_errors++; $display("FAIL reset_change: got %0d/%0d expected 0/0", change_a, change_b);
      end
   endtask

   task automatic test_legal_cycle();
      int   chg_a = 0;
      int   chg_b = 0;
      logic saw_fault = 1'b0;
      do_reset();
      for (int i = 0; i < 28; i++) begin
         step((i < 2) ? R : (i < 22) ? G : (i < 27) ? Y : R, R);
         chg_a += int'(change_a);
         saw_fault |= fault;
         if (i == 21) begin
            num_checks++;
            if (dwell_a !== 32'd20) begin num_errors++; $display("FAIL legal_dwell_a: got %0d expected 20", dwell_a); end
         end
      end
      for (int i = 0; i < 28; i++) begin
         step(R, (i < 2) ? R : (i < 22) ? G : (i < 27) ? Y : R);
         chg_b += int'(change_b);
         saw_fault |= fault;
         if (i == 21) begin
            num_checks++;
            if (dwell_b !== 32'd20) begin num_errors++; $display("FAIL legal_dwell_b: got %0d expected 20", dwell_b); end
         end
      end
      num_checks++;
      if (saw_fault !== 1'b0) begin num_errors++; $display("FAIL legal_no_fault: got %0d expected 0", saw_fault); end
      num_checks++;
      if (chg_a != 3) begin num_errors++; $display("FAIL legal_changes_a: got %0d expected 3", chg_a); end
      num_checks++;
      if (chg_b != 3) begin num_errors++; $display("FAIL legal_changes_b: got %0d expected 3", chg_b); end
   endtask

   task automatic test_conflict();
      do_reset();
      step(G, Y);
      num_checks++;
      if (fault !== 1'b1 || fault_code !== 3'd3 || fault_count !== 8'd1) begin
         num_errors++;
         $display("FAIL conflict_first: got fault=%0d code=%0d count=%0d expected 1/3/1", fault, fault_code, fault_count);
      end
      step(G, Y);
      step(G, Y);
      num_checks++;
      if (fault_code !== 3'd3 || fault_count !== 8'd3) begin
         num_errors++;
         $display("FAIL conflict_hold: got code=%0d count=%0d expected 3/3", fault_code, fault_count);
      end
   endtask

   task automatic test_short_green();
      do_reset();
      for (int i = 0; i < 10; i++) step(G, R);
      num_checks++;
      if (fault !== 1'b0) begin num_errors++; $display("FAIL sgreen_before: got %0d expected 0", fault); end
      step(Y, R);
      num_checks++;
      if (fault_code !== 3'd4 || fault_lane !== 1'b0) begin
         num_errors++; $display("FAIL sgreen_code: got code=%0d lane=%0d expected 4/0", fault_code, fault_lane);
      end
      num_checks++;
      if (dwell_a !== 32'd1) begin num_errors++; $display("FAIL sgreen_dwell: got %0d expected 1", dwell_a); end
   endtask

   task automatic test_clearance_and_clear();
      do_reset();
      for (int i = 0; i < 26; i++) step((i < 20) ? G : (i < 25) ? Y : R, R);
      num_checks++;
      if (fault !== 1'b0) begin num_errors++; $display("FAIL clr_legal_a: got %0d expected 0", fault); end
      step(R, G);
      num_checks++;
      if (fault_code !== 3'd7 || fault_lane !== 1'b1 || fault_count !== 8'd1) begin
         num_errors++;
         $display("FAIL clr_code7: got code=%0d lane=%0d count=%0d expected 7/1/1", fault_code, fault_lane, fault_count);
      end
      clear = 1'b1;
      step(R, R);
      clear = 1'b0;
      num_checks++;
      if (fault !== 1'b1 || fault_code !== 3'd2 || fault_lane !== 1'b1 || fault_count !== 8'd1) begin
         num_errors++;
         $display("FAIL clr_same_cycle: got fault=%0d code=%0d lane=%0d count=%0d expected 1/2/1/1",
                  fault, fault_code, fault_lane, fault_count);
      end
      clear = 1'b1;
      step(R, R);
      clear = 1'b0;
      num_checks++;
      if (fault !== 1'b0 || fault_code !== 3'd0 || fault_count !== 8'd0) begin
         num_errors++;
         $display("FAIL clr_plain: got fault=%0d code=%0d count=%0d expected 0/0/0", fault, fault_code, fault_count);
      end
   endtask

   task automatic test_timeout_and_encoding();
      int first_at = 0;
      do_reset();
      for (int i = 1; i <= 250; i++) begin
         step(R, R);
         if (fault === 1'b1 && first_at == 0) first_at = i;
      end
      num_checks++;
      if (first_at != 200) begin num_errors++; $display("FAIL timeout_at: got %0d expected 200", first_at); end
      num_checks++;
      if (fault_code !== 3'd6 || fault_lane !== 1'b0 || fault_count !== 8'd1) begin
         num_errors++;
         $display("FAIL timeout_once: got code=%0d lane=%0d count=%0d expected 6/0/1", fault_code, fault_lane, fault_count);
      end
      clear = 1'b1;
      step(R, R);
      clear = 1'b0;
      num_checks++;
      if (fault !== 1'b0 || dwell_a !== 32'd251) begin
         num_errors++; $display("FAIL timeout_clear: got fault=%0d dwell=%0d expected 0/251", fault, dwell_a);
      end
      step(X, R);
      num_checks++;
      if (fault_code !== 3'd1 || fault_lane !== 1'b0) begin
         num_errors++; $display("FAIL enc_code: got code=%0d lane=%0d expected 1/0", fault_code, fault_lane);
      end
      num_checks++;
      if (dwell_a !== 32'd251 || change_a !== 1'b0) begin
         num_errors++; $display("FAIL enc_hold: got dwell=%0d change=%0d expected 251/0", dwell_a, change_a);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 22; i++) step((i < 20) ? G : Y, R);
      step(Y, X);
      num_checks++;
      if (fault !== 1'b1) begin num_errors++; $display("FAIL mid_pre_fault: got %0d expected 1", fault); end
      reset = 1'b1;
      step(Y, R);
      reset = 1'b0;
      num_checks++;
      if (fault !== 1'b0 || fault_code !== 3'd0 || fault_count !== 8'd0 || dwell_a !== 32'd0 || change_a !== 1'b0) begin
         num_errors++;
         $display("FAIL mid_reset: got fault=%0d code=%0d count=%0d dwell=%0d change=%0d expected all 0",
                  fault, fault_code, fault_count, dwell_a, change_a);
      end
      step(G, R);
      num_checks++;
      if (fault !== 1'b0 || change_a !== 1'b1 || dwell_a !== 32'd1) begin
         num_errors++;
         $display("FAIL mid_green: got fault=%0d change=%0d dwell=%0d expected 0/1/1", fault, change_a, dwell_a);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      clear   = 1'b0;
      light_a = R;
      light_b = R;
      test_reset();
      test_legal_cycle();
      test_conflict();
      test_short_green();
      test_clearance_and_clear();
      test_timeout_and_encoding();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
